ppl_fp_addsub_vec: RTL

//   Parametrised, multi-lane, pipelined floating-point add/sub (IEEE-style sign/exp/frac, bias 2^(EXP_W-1)-1).

---
 rtl/ppl_fp_addsub_vec.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ppl_fp_addsub_vec.sv
// ppl_fp_addsub_vec
//   Multi-lane, 4-stage pipelined floating-point add/sub with valid/ready
//   backpressure, selectable rounding (RNE / RTZ), per-lane exception flags
//   and a sideband tag that travels with each beat.
//   Stages: S1 unpack/special/swap, S2 align+add, S3 LZC+normalise,
//           S4 round/pack into the output registers.
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake (in_ready = pipeline may advance)
//   in_a, in_b             operands, lane i at [i*W +: W]
//   in_sub                 per-lane subtract select (1 = A-B)
//   in_rmode               0 = round-nearest-even, 1 = round-toward-zero
//   in_tag                 sideband tag
//   out_valid/out_ready    output handshake
//   out_result             results, same packing as operands
//   out_flags              per lane {invalid, overflow, underflow, inexact}
//   out_tag                tag of the beat on the output
module ppl_fp_addsub_vec #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 7,
    parameter int LANES  = 4,
    parameter int TAG_W  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES*(1+EXP_W+FRAC_W)-1:0]    in_a,
    input  logic [LANES*(1+EXP_W+FRAC_W)-1:0]    in_b,
    input  logic [LANES-1:0]                     in_sub,
    input  logic                                 in_rmode,
    input  logic [TAG_W-1:0]                     in_tag,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [LANES*(1+EXP_W+FRAC_W)-1:0]    out_result,
    output logic [LANES*4-1:0]                   out_flags,
    output logic [TAG_W-1:0]                     out_tag
);
    localparam int W   = 1 + EXP_W + FRAC_W;
    localparam int MW  = FRAC_W + 1;            // mantissa incl. hidden bit
    localparam int XW  = FRAC_W + 4;            // mantissa + guard/round/sticky
    localparam int SW  = FRAC_W + 5;            // XW plus carry-out
    localparam int EW  = EXP_W + 2;             // signed working exponent
    localparam int LZW = $clog2(XW + 1);
    localparam logic [EXP_W-1:0] EMAX   = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(FRAC_W + 3);
    localparam logic [W-1:0]     QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    logic             w_adv;
    logic             r_v1, r_v2, r_v3, r_out_valid;
    logic             r_rm1, r_rm2, r_rm3;
    logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3, r_out_tag;

    // Every stage moves together; no bubble collapse, so a stall freezes the whole pipe.
    assign w_adv     = ~r_out_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out_tag   = r_out_tag;

    // Beat-level control: stage valids, rounding mode and tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0; r_out_valid <= 1'b0;
            r_rm1 <= 1'b0; r_rm2 <= 1'b0; r_rm3 <= 1'b0;
            r_tag1 <= {TAG_W{1'b0}}; r_tag2 <= {TAG_W{1'b0}};
            r_tag3 <= {TAG_W{1'b0}}; r_out_tag <= {TAG_W{1'b0}};
        end else if (w_adv) begin
            r_v1 <= in_valid; r_v2 <= r_v1; r_v3 <= r_v2; r_out_valid <= r_v3;
            r_rm1 <= in_rmode; r_rm2 <= r_rm1; r_rm3 <= r_rm2;
            r_tag1 <= in_tag; r_tag2 <= r_tag1; r_tag3 <= r_tag2; r_out_tag <= r_tag3;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [W-1:0]     w_a, w_b;
        logic             w_sa, w_sb;
        logic [EXP_W-1:0] w_ea, w_eb;
        logic [FRAC_W-1:0] w_fa, w_fb;
        logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_b_gt;
        logic             w_s1_spec;
        logic [W-1:0]     w_s1_sres;
        logic [3:0]       w_s1_sflags;

        assign w_a  = in_a[i*W +: W];
        assign w_b  = in_b[i*W +: W];
        assign w_sa = w_a[W-1];
        assign w_sb = w_b[W-1] ^ in_sub[i];     // effective sign of B
        assign w_ea = w_a[W-2 -: EXP_W];
        assign w_eb = w_b[W-2 -: EXP_W];
        assign w_fa = w_a[FRAC_W-1:0];
        assign w_fb = w_b[FRAC_W-1:0];
        assign w_a_nan  = (w_ea == EMAX) & (|w_fa);
        assign w_b_nan  = (w_eb == EMAX) & (|w_fb);
        assign w_a_inf  = (w_ea == EMAX) & ~(|w_fa);
        assign w_b_inf  = (w_eb == EMAX) & ~(|w_fb);
        assign w_a_zero = (w_ea == {EXP_W{1'b0}});   // subnormals read as zero
        assign w_b_zero = (w_eb == {EXP_W{1'b0}});
        assign w_b_gt   = {w_eb, w_fb} > {w_ea, w_fa};

        // S1 special-case resolution in priority order.
        always_comb begin
            w_s1_spec   = 1'b1;
            w_s1_sres   = QNAN;
            w_s1_sflags = 4'b0000;
            if (w_a_nan | w_b_nan) begin
                w_s1_sres = QNAN;
            end else if (w_a_inf & w_b_inf & (w_sa != w_sb)) begin
                w_s1_sflags = 4'b1000;
            end else if (w_a_inf) begin
                w_s1_sres = {w_sa, EMAX, {FRAC_W{1'b0}}};
            end else if (w_b_inf) begin
                w_s1_sres = {w_sb, EMAX, {FRAC_W{1'b0}}};
            end else if (w_a_zero & w_b_zero) begin
                w_s1_sres = {w_sa & w_sb, {(W-1){1'b0}}};
            end else if (w_a_zero) begin
                w_s1_sres = {w_sb, w_eb, w_fb};
            end else if (w_b_zero) begin
                w_s1_sres = {w_sa, w_ea, w_fa};
            end else begin
                w_s1_spec = 1'b0;
                w_s1_sres = {W{1'b0}};
            end
        end

        logic             r1_spec, r1_sign, r1_esub;
        logic [W-1:0]     r1_sres;
        logic [3:0]       r1_sflags;
        logic [EXP_W-1:0] r1_exp, r1_diff;
        logic [MW-1:0]    r1_ml, r1_ms;

        // S2: align smaller operand (shift saturates so it all lands in sticky), then add/sub.
        logic [EXP_W-1:0] w_sh;
        logic [2*XW-1:0]  w_wide;
        logic [XW-1:0]    w_al;
        logic [SW-1:0]    w_sum;
        assign w_sh   = (r1_diff > SH_MAX) ? SH_MAX : r1_diff;
        assign w_wide = {r1_ms, 3'b000, {XW{1'b0}}} >> w_sh;
        assign w_al   = {w_wide[2*XW-1:XW+1], |w_wide[XW:0]};
        assign w_sum  = r1_esub ? ({1'b0, r1_ml, 3'b000} - {1'b0, w_al})
                                : ({1'b0, r1_ml, 3'b000} + {1'b0, w_al});

        logic             r2_spec, r2_sign;
        logic [W-1:0]     r2_sres;
        logic [3:0]       r2_sflags;
        logic [EXP_W-1:0] r2_exp;
        logic [SW-1:0]    r2_sum;

        // S3: leading-zero count and normalisation. The exponent is kept signed so an
        // over-cancelled result shows up as exp <= 0 and is flushed in S4.
        logic [LZW-1:0]        w_lzc;
        logic [XW-1:0]         w_norm;
        logic signed [EW-1:0]  w_exp_n;
        always_comb begin
            w_lzc = LZW'(XW);
            for (int k = 0; k < XW; k++) begin
                if (r2_sum[k]) begin
                    w_lzc = LZW'(XW - 1 - k);
                end else begin
                    w_lzc = w_lzc;
                end
            end
            if (r2_sum[SW-1]) begin
                w_norm  = {r2_sum[SW-1:2], |r2_sum[1:0]};
                w_exp_n = $signed({2'b00, r2_exp}) + $signed(EW'(1));
            end else begin
                w_norm  = r2_sum[XW-1:0] << w_lzc;
                w_exp_n = $signed({2'b00, r2_exp}) - $signed({{(EW-LZW){1'b0}}, w_lzc});
            end
        end

        logic                  r3_spec, r3_sign, r3_zero;
        logic [W-1:0]          r3_sres;
        logic [3:0]            r3_sflags;
        logic signed [EW-1:0]  r3_exp;
        logic [XW-1:0]         r3_norm;

        // S4: rounding; a mantissa carry bumps the exponent and leaves a zero fraction.
        logic                  w_up, w_inx;
        logic [MW:0]           w_mr;
        logic signed [EW-1:0]  w_exp_f;
        logic [FRAC_W-1:0]     w_frac;
        logic [W-1:0]          w_res;
        logic [3:0]            w_flg;
        assign w_up    = ~r_rm3 & r3_norm[2] & (r3_norm[1] | r3_norm[0] | r3_norm[3]);
        assign w_inx   = |r3_norm[2:0];
        assign w_mr    = {1'b0, r3_norm[XW-1:3]} + {{MW{1'b0}}, w_up};
        assign w_exp_f = r3_exp + $signed({{(EW-1){1'b0}}, w_mr[MW]});
        assign w_frac  = w_mr[MW] ? w_mr[FRAC_W:1] : w_mr[FRAC_W-1:0];

        // S4 result selection: special, exact zero, underflow, overflow, normal.
        always_comb begin
            w_res = {W{1'b0}};
            w_flg = 4'b0000;
            if (r3_spec) begin
                w_res = r3_sres;
                w_flg = r3_sflags;
            end else if (r3_zero) begin
                w_res = {W{1'b0}};
            end else if (w_exp_f <= $signed({EW{1'b0}})) begin
                w_res = {r3_sign, {(W-1){1'b0}}};
                w_flg = 4'b0011;
            end else if (w_exp_f >= $signed({2'b00, EMAX})) begin
                w_flg = 4'b0101;
                if (r_rm3) begin
                    w_res = {r3_sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
                end else begin
                    w_res = {r3_sign, EMAX, {FRAC_W{1'b0}}};
                end
            end else begin
                w_res = {r3_sign, w_exp_f[EXP_W-1:0], w_frac};
                w_flg = {3'b000, w_inx};
            end
        end

        logic [W-1:0] r_res;
        logic [3:0]   r_flg;

        // Lane datapath registers for all four stages.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r1_spec <= 1'b0; r1_sign <= 1'b0; r1_esub <= 1'b0; r1_sres <= {W{1'b0}};
                r1_sflags <= 4'b0000; r1_exp <= {EXP_W{1'b0}}; r1_diff <= {EXP_W{1'b0}};
                r1_ml <= {MW{1'b0}}; r1_ms <= {MW{1'b0}};
                r2_spec <= 1'b0; r2_sign <= 1'b0; r2_sres <= {W{1'b0}}; r2_sflags <= 4'b0000;
                r2_exp <= {EXP_W{1'b0}}; r2_sum <= {SW{1'b0}};
                r3_spec <= 1'b0; r3_sign <= 1'b0; r3_zero <= 1'b0; r3_sres <= {W{1'b0}};
                r3_sflags <= 4'b0000; r3_exp <= {EW{1'b0}}; r3_norm <= {XW{1'b0}};
                r_res <= {W{1'b0}}; r_flg <= 4'b0000;
            end else if (w_adv) begin
                r1_spec   <= w_s1_spec;
                r1_sres   <= w_s1_sres;
                r1_sflags <= w_s1_sflags;
                r1_sign   <= w_b_gt ? w_sb : w_sa;
                r1_esub   <= w_sa ^ w_sb;
                r1_exp    <= w_b_gt ? w_eb : w_ea;
                r1_diff   <= w_b_gt ? (w_eb - w_ea) : (w_ea - w_eb);
                r1_ml     <= w_b_gt ? {1'b1, w_fb} : {1'b1, w_fa};
                r1_ms     <= w_b_gt ? {1'b1, w_fa} : {1'b1, w_fb};
                r2_spec <= r1_spec; r2_sign <= r1_sign; r2_sres <= r1_sres;
                r2_sflags <= r1_sflags; r2_exp <= r1_exp; r2_sum <= w_sum;
                r3_spec <= r2_spec; r3_sign <= r2_sign; r3_sres <= r2_sres;
                r3_sflags <= r2_sflags; r3_zero <= ~(|r2_sum); r3_exp <= w_exp_n; r3_norm <= w_norm;
                r_res <= w_res;
                r_flg <= w_flg;
            end
        end

        assign out_result[i*W +: W] = r_res;
        assign out_flags[i*4 +: 4]  = r_flg;
    end
endmodule
